// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the multi-port register file.
//   REGFILE_DATA_WIDTH / REGFILE_ADDR_WIDTH : default register width and
//                                             address width.
//   REGFILE_ZERO_ADDR                       : address of the hardwired zero
//                                             register.
//   REGFILE_MAX_WRITE                       : widest write-port count the
//                                             collision helper resolves.
//   regfile_win_port()                      : picks the winning write port
//                                             from a per-port hit vector.
// Optional feature macro used by the design: REGFILE_FWD_EN.
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int REGFILE_DATA_WIDTH = 32;
   localparam int REGFILE_ADDR_WIDTH = 5;
   localparam int REGFILE_MAX_WRITE  = 2;
   localparam int REGFILE_WIDX       = 1;

   localparam logic [REGFILE_ADDR_WIDTH-1:0] REGFILE_ZERO_ADDR = 5'd0;

   typedef struct packed {
      logic                    valid;
      logic [REGFILE_WIDX-1:0] idx;
   } regfile_win_t;

   // Highest-indexed hitting port wins: later loop iterations override.
   function automatic regfile_win_t regfile_win_port(
      input logic [REGFILE_MAX_WRITE-1:0] hit
   );
      regfile_win_t res;
      res.valid = 1'b0;
      res.idx   = '0;
      for (int w = 0; w < REGFILE_MAX_WRITE; w++) begin
         if (hit[w]) begin
            res.valid = 1'b1;
            res.idx   = REGFILE_WIDX'(w);
         end else begin
            res.valid = res.valid;
         end
      end
      return res;
   endfunction

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One registered read port of the register file.
//   clk, rst  : clock, asynchronous active-high reset
//   rd_addr   : read address
//   rd_en     : read enable; when low rd_data holds (decode stall)
//   regs      : current register array contents
//   wr_en/wr_addr/wr_data : this cycle's write ports (used for forwarding)
//   rd_data   : registered read data
// Macro REGFILE_FWD_EN: when defined, a same-cycle write to rd_addr is
// forwarded (write-first); otherwise the pre-write contents are returned.
// -----------------------------------------------------------------------------
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
   parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
   parameter int NUM_WRITE  = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [ADDR_WIDTH-1:0]                rd_addr,
   input  logic                                 rd_en,
   input  logic [DATA_WIDTH-1:0]                regs [2**ADDR_WIDTH],
   input  logic [NUM_WRITE-1:0]                 wr_en,
   input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0]                rd_data
);

   logic [DATA_WIDTH-1:0] array_data_s;
   logic [DATA_WIDTH-1:0] fwd_data_s;
   logic [DATA_WIDTH-1:0] next_data_s;
   logic [DATA_WIDTH-1:0] rd_data_r;

   // Array read mux.
   always_comb begin
      array_data_s = regs[rd_addr];
   end

`ifdef REGFILE_FWD_EN
   // Forwarding mux: replace array data with the winning same-cycle write.
   always_comb begin : fwd_mux
      logic [REGFILE_MAX_WRITE-1:0] hit_v;
      regfile_win_t                 win_v;
      hit_v = '0;
      for (int w = 0; w < NUM_WRITE; w++) begin
         hit_v[w] = wr_en[w] && (wr_addr[w] == rd_addr);
      end
      win_v      = regfile_win_port(hit_v);
      fwd_data_s = array_data_s;
      for (int w = 0; w < NUM_WRITE; w++) begin
         if (win_v.valid && (int'(win_v.idx) == w)) begin
            fwd_data_s = wr_data[w];
         end else begin
            fwd_data_s = fwd_data_s;
         end
      end
   end
`else
   logic unused_wr_s;
   assign unused_wr_s = ^{wr_en, wr_addr, wr_data};

   // Read-first build: no forwarding path.
   always_comb begin
      fwd_data_s = array_data_s;
   end
`endif

   // Zero-register gating; also blocks forwarding of writes to address 0.
   always_comb begin
      if ((ZERO_REG == 1) && (rd_addr == ADDR_WIDTH'(REGFILE_ZERO_ADDR))) begin
         next_data_s = '0;
      end else begin
         next_data_s = fwd_data_s;
      end
   end

   // Enable-gated output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_r <= '0;
      end else if (rd_en) begin
         rd_data_r <= next_data_s;
      end else begin
         rd_data_r <= rd_data_r;
      end
   end

   assign rd_data = rd_data_r;

endmodule : regfile_read_port

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file for the decode stage.
//   clk, rst  : clock, asynchronous active-high reset (clears array and
//               all read outputs)
//   readReg   : per-read-port address
//   readEn    : per-read-port enable; readData holds when low
//   readData  : registered read data, 1-cycle latency
//   writeReg/writeData/write : write ports; on an address collision the
//               highest-indexed port wins
// Parameters: DATA_WIDTH, ADDR_WIDTH, NUM_READ (1..4), NUM_WRITE (1..2),
//             ZERO_REG (1: register 0 hardwired to zero).
// Macro REGFILE_FWD_EN: enables same-cycle write-to-read forwarding.
// -----------------------------------------------------------------------------
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
   parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
   parameter int NUM_READ   = 2,
   parameter int NUM_WRITE  = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  readReg,
   input  logic [NUM_READ-1:0]                  readEn,
   output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  readData,
   input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] writeReg,
   input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] writeData,
   input  logic [NUM_WRITE-1:0]                 write
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_r     [DEPTH];
   logic                  wr_valid_s [DEPTH];
   logic [DATA_WIDTH-1:0] wr_value_s [DEPTH];

   // Per-register write resolution: winning port, dropped zero-register writes.
   always_comb begin : wr_resolve
      logic [REGFILE_MAX_WRITE-1:0] hit_v;
      regfile_win_t                 win_v;
      for (int a = 0; a < DEPTH; a++) begin
         hit_v = '0;
         for (int w = 0; w < NUM_WRITE; w++) begin
            hit_v[w] = write[w] && (writeReg[w] == ADDR_WIDTH'(a));
         end
         win_v         = regfile_win_port(hit_v);
         wr_value_s[a] = writeData[0];
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (win_v.valid && (int'(win_v.idx) == w)) begin
               wr_value_s[a] = writeData[w];
            end else begin
               wr_value_s[a] = wr_value_s[a];
            end
         end
         wr_valid_s[a] = win_v.valid && !((ZERO_REG == 1) && (a == 0));
      end
   end

   // Register array storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < DEPTH; a++) begin
            regs_r[a] <= '0;
         end
      end else begin
         for (int a = 0; a < DEPTH; a++) begin
            if (wr_valid_s[a]) begin
               regs_r[a] <= wr_value_s[a];
            end else begin
               regs_r[a] <= regs_r[a];
            end
         end
      end
   end

   for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
      regfile_read_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .NUM_WRITE  (NUM_WRITE),
         .ZERO_REG   (ZERO_REG)
      ) u_read_port (
         .clk     (clk),
         .rst     (rst),
         .rd_addr (readReg[r]),
         .rd_en   (readEn[r]),
         .regs    (regs_r),
         .wr_en   (write),
         .wr_addr (writeReg),
         .wr_data (writeData),
         .rd_data (readData[r])
      );
   end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Drives two register files (ZERO_REG=1 and ZERO_REG=0) with shared stimulus:
// a directed vector table, a mid-operation reset sequence and a random run
// against a behavioural model. Expectations follow REGFILE_FWD_EN.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;

`ifdef REGFILE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NR-1:0][AW-1:0] readReg;
   logic [NR-1:0]         readEn;
   logic [NR-1:0][DW-1:0] rd_z;
   logic [NR-1:0][DW-1:0] rd_nz;
   logic [NW-1:0][AW-1:0] writeReg;
   logic [NW-1:0][DW-1:0] writeData;
   logic [NW-1:0]         write;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(1)) u_dut_z (
      .clk       (clk),
      .rst       (rst),
      .readReg   (readReg),
      .readEn    (readEn),
      .readData  (rd_z),
      .writeReg  (writeReg),
      .writeData (writeData),
      .write     (write)
   );

   regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(0)) u_dut_nz (
      .clk       (clk),
      .rst       (rst),
      .readReg   (readReg),
      .readEn    (readEn),
      .readData  (rd_nz),
      .writeReg  (writeReg),
      .writeData (writeData),
      .write     (write)
   );

   typedef struct {
      logic [1:0]    we;
      logic [AW-1:0] wa0;
      logic [DW-1:0] wd0;
      logic [AW-1:0] wa1;
      logic [DW-1:0] wd1;
      logic [1:0]    re;
      logic [AW-1:0] ra0;
      logic [AW-1:0] ra1;
      logic [DW-1:0] ez0;
      logic [DW-1:0] ez1;
      logic [DW-1:0] en0;
      logic [DW-1:0] en1;
   } vec_t;

   vec_t vecs [14];

   logic [DW-1:0] mem_z  [32];
   logic [DW-1:0] mem_nz [32];
   logic [DW-1:0] exp_z  [NR];
   logic [DW-1:0] exp_nz [NR];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic idle_inputs();
      write     = 2'b00;
      writeReg  = '0;
      writeData = '0;
      readEn    = 2'b00;
      readReg   = '0;
   endtask

   // Behavioural model of one clock edge using the current inputs.
   task automatic model_step();
      logic [DW-1:0] fwd;
      bit            hit;
      for (int r = 0; r < NR; r++) begin
         hit = 1'b0;
         fwd = '0;
         for (int w = 0; w < NW; w++) begin
            if (write[w] && (writeReg[w] == readReg[r])) begin
               hit = 1'b1;
               fwd = writeData[w];
            end
         end
         if (readEn[r]) begin
            exp_nz[r] = (FWD && hit) ? fwd : mem_nz[readReg[r]];
            if (readReg[r] == 5'd0) exp_z[r] = 32'd0;
            else exp_z[r] = (FWD && hit) ? fwd : mem_z[readReg[r]];
         end
      end
      for (int w = 0; w < NW; w++) begin
         if (write[w]) begin
            mem_nz[writeReg[w]] = writeData[w];
            if (writeReg[w] != 5'd0) mem_z[writeReg[w]] = writeData[w];
         end
      end
   endtask

   initial begin
      vecs[0]  = '{2'b11, 5'd3,  32'd3,          5'd4,  32'd4,          2'b11, 5'd1,  5'd2,
                   32'd0, 32'd0, 32'd0, 32'd0};
      vecs[1]  = '{2'b11, 5'd9,  32'd1,          5'd7,  32'h11,         2'b11, 5'd3,  5'd4,
                   32'd3, 32'd4, 32'd3, 32'd4};
      vecs[2]  = '{2'b11, 5'd7,  32'h11111111,   5'd7,  32'h22222222,   2'b11, 5'd9,  5'd3,
                   32'd1, 32'd3, 32'd1, 32'd3};
      vecs[3]  = '{2'b00, 5'd0,  32'd0,          5'd0,  32'd0,          2'b11, 5'd7,  5'd7,
                   32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222};
      vecs[4]  = '{2'b01, 5'd9,  32'hA5A5A5A5,   5'd0,  32'd0,          2'b11, 5'd9,  5'd7,
                   FWD ? 32'hA5A5A5A5 : 32'h1, 32'h22222222,
                   FWD ? 32'hA5A5A5A5 : 32'h1, 32'h22222222};
      vecs[5]  = '{2'b00, 5'd0,  32'd0,          5'd0,  32'd0,          2'b01, 5'd9,  5'd3,
                   32'hA5A5A5A5, 32'h22222222, 32'hA5A5A5A5, 32'h22222222};
      vecs[6]  = '{2'b00, 5'd0,  32'd0,          5'd0,  32'd0,          2'b01, 5'd3,  5'd3,
                   32'd3, 32'h22222222, 32'd3, 32'h22222222};
      vecs[7]  = '{2'b00, 5'd0,  32'd0,          5'd0,  32'd0,          2'b10, 5'd4,  5'd4,
                   32'd3, 32'd4, 32'd3, 32'd4};
      vecs[8]  = '{2'b00, 5'd0,  32'd0,          5'd0,  32'd0,          2'b10, 5'd4,  5'd0,
                   32'd3, 32'd0, 32'd3, 32'd0};
      vecs[9]  = '{2'b00, 5'd0,  32'd0,          5'd0,  32'd0,          2'b01, 5'd4,  5'd0,
                   32'd4, 32'd0, 32'd4, 32'd0};
      vecs[10] = '{2'b11, 5'd0,  32'hFF,         5'd0,  32'hFF,         2'b11, 5'd0,  5'd0,
                   32'd0, 32'd0, FWD ? 32'hFF : 32'd0, FWD ? 32'hFF : 32'd0};
      vecs[11] = '{2'b00, 5'd0,  32'd0,          5'd0,  32'd0,          2'b11, 5'd0,  5'd0,
                   32'd0, 32'd0, 32'hFF, 32'hFF};
      vecs[12] = '{2'b11, 5'd12, 32'hAAAA0000,   5'd12, 32'h0000BBBB,   2'b11, 5'd12, 5'd12,
                   FWD ? 32'h0000BBBB : 32'd0, FWD ? 32'h0000BBBB : 32'd0,
                   FWD ? 32'h0000BBBB : 32'd0, FWD ? 32'h0000BBBB : 32'd0};
      vecs[13] = '{2'b00, 5'd0,  32'd0,          5'd0,  32'd0,          2'b11, 5'd12, 5'd5,
                   32'h0000BBBB, 32'd0, 32'h0000BBBB, 32'd0};

      // Power-on reset.
      rst = 1'b1;
      idle_inputs();
      #3;
      for (int r = 0; r < NR; r++) begin
         check($sformatf("por_z_p%0d", r), rd_z[r], 32'd0);
         check($sformatf("por_nz_p%0d", r), rd_nz[r], 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Directed vector table.
      for (int i = 0; i < 14; i++) begin
         write        = vecs[i].we;
         writeReg[0]  = vecs[i].wa0;
         writeData[0] = vecs[i].wd0;
         writeReg[1]  = vecs[i].wa1;
         writeData[1] = vecs[i].wd1;
         readEn       = vecs[i].re;
         readReg[0]   = vecs[i].ra0;
         readReg[1]   = vecs[i].ra1;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d_z_p0", i),  rd_z[0],  vecs[i].ez0);
         check($sformatf("vec%0d_z_p1", i),  rd_z[1],  vecs[i].ez1);
         check($sformatf("vec%0d_nz_p0", i), rd_nz[0], vecs[i].en0);
         check($sformatf("vec%0d_nz_p1", i), rd_nz[1], vecs[i].en1);
      end
      idle_inputs();

      // Reset in the middle of operation.
      write        = 2'b01;
      writeReg[0]  = 5'd5;
      writeData[0] = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      readEn  = 2'b11;
      readReg = {5'd5, 5'd5};
      @(posedge clk);
      @(negedge clk);
      check("x5_before_rst_z",  rd_z[0],  32'hDEADBEEF);
      check("x5_before_rst_nz", rd_nz[1], 32'hDEADBEEF);
      write        = 2'b01;
      writeReg[0]  = 5'd5;
      writeData[0] = 32'h12345678;
      #2;
      rst = 1'b1;
      #1;
      for (int r = 0; r < NR; r++) begin
         check($sformatf("rst_async_z_p%0d", r), rd_z[r], 32'd0);
         check($sformatf("rst_async_nz_p%0d", r), rd_nz[r], 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      readEn  = 2'b11;
      readReg = {5'd12, 5'd5};
      @(posedge clk);
      @(negedge clk);
      check("x5_after_rst_z",   rd_z[0],  32'd0);
      check("x5_after_rst_nz",  rd_nz[0], 32'd0);
      check("x12_after_rst_z",  rd_z[1],  32'd0);
      check("x12_after_rst_nz", rd_nz[1], 32'd0);
      idle_inputs();

      // Random mixed traffic against the model.
      for (int a = 0; a < 32; a++) begin
         mem_z[a]  = 32'd0;
         mem_nz[a] = 32'd0;
      end
      for (int r = 0; r < NR; r++) begin
         exp_z[r]  = 32'd0;
         exp_nz[r] = 32'd0;
      end
      for (int c = 0; c < 300; c++) begin
         write  = 2'($urandom_range(0, 3));
         readEn = 2'($urandom_range(0, 3));
         for (int w = 0; w < NW; w++) begin
            writeReg[w]  = 5'($urandom_range(0, 7));
            writeData[w] = $urandom;
         end
         for (int r = 0; r < NR; r++) begin
            readReg[r] = 5'($urandom_range(0, 7));
         end
         model_step();
         @(posedge clk);
         @(negedge clk);
         for (int r = 0; r < NR; r++) begin
            check($sformatf("rnd%0d_z_p%0d", c, r),  rd_z[r],  exp_z[r]);
            check($sformatf("rnd%0d_nz_p%0d", c, r), rd_nz[r], exp_nz[r]);
         end
      end
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_regfile_mp
